// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with registered, write-first read
// ports, a per-register busy scoreboard, and a valid/ready dump sequencer.
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   WE, WrReg, InData     - write port (out-of-range or hardwired-zero writes dropped)
//   ReadA/ReadB -> OutA/OutB, BusyA/BusyB  - registered read data and busy bits
//   MarkBusy, MarkReg     - set a scoreboard busy bit
//   DumpStart, DumpReady  - dump request and consumer handshake
//   DumpValid, DumpIdx, DumpData, DumpDone - dump stream and completion pulse
module regfile_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NREGS    = 4,
    parameter int unsigned ZERO_REG = 0,
    localparam int unsigned ADDR_W  = ($clog2(NREGS) < 1) ? 1 : $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WrReg,
    input  logic [WIDTH-1:0]  InData,
    input  logic [ADDR_W-1:0] ReadA,
    input  logic [ADDR_W-1:0] ReadB,
    output logic [WIDTH-1:0]  OutA,
    output logic [WIDTH-1:0]  OutB,
    input  logic              MarkBusy,
    input  logic [ADDR_W-1:0] MarkReg,
    output logic              BusyA,
    output logic              BusyB,
    input  logic              DumpStart,
    input  logic              DumpReady,
    output logic              DumpValid,
    output logic [ADDR_W-1:0] DumpIdx,
    output logic [WIDTH-1:0]  DumpData,
    output logic              DumpDone
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [WIDTH-1:0]  regs     [NREGS];
    logic [WIDTH-1:0]  regsNext [NREGS];
    logic [NREGS-1:0]  wrHit;
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busyNext;
    logic [WIDTH-1:0]  rdA;
    logic [WIDTH-1:0]  rdB;
    logic [WIDTH-1:0]  rdInc;
    logic              bzA;
    logic              bzB;
    logic [ADDR_W-1:0] idxInc;

    logic [1:0]        state;
    logic [1:0]        stateNext;
    logic              dumpValidNext;
    logic              dumpDoneNext;
    logic [ADDR_W-1:0] dumpIdxNext;
    logic [WIDTH-1:0]  dumpDataNext;

    assign idxInc = DumpIdx + ADDR_W'(1);

    // Write decode and scoreboard update; the mark loop runs last so mark wins.
    // Addresses with no matching entry (out of range) simply never hit.
    always_comb begin
        wrHit    = '0;
        busyNext = busy;
        for (int i = 0; i < NREGS; i++) begin
            if (!(ZERO_REG != 0 && i == 0) && WE && WrReg == ADDR_W'(i)) begin
                wrHit[i]    = 1'b1;
                busyNext[i] = 1'b0;
            end
        end
        for (int i = 0; i < NREGS; i++) begin
            if (!(ZERO_REG != 0 && i == 0) && MarkBusy && MarkReg == ADDR_W'(i)) begin
                busyNext[i] = 1'b1;
            end
        end
    end

    // Post-write view of the array; gives the write-first bypass for every reader.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regsNext[i] = wrHit[i] ? InData : regs[i];
        end
    end

    // Read muxes; out-of-range addresses fall through to 0.
    always_comb begin
        rdA   = '0;
        rdB   = '0;
        rdInc = '0;
        bzA   = 1'b0;
        bzB   = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (ReadA == ADDR_W'(i)) begin
                rdA = regsNext[i];
                bzA = busyNext[i];
            end
            if (ReadB == ADDR_W'(i)) begin
                rdB = regsNext[i];
                bzB = busyNext[i];
            end
            if (idxInc == ADDR_W'(i)) begin
                rdInc = regsNext[i];
            end
        end
    end

    // Dump sequencer next-state and next-output logic.
    always_comb begin
        stateNext     = state;
        dumpValidNext = DumpValid;
        dumpIdxNext   = DumpIdx;
        dumpDataNext  = DumpData;
        dumpDoneNext  = 1'b0;
        case (state)
            IDLE: begin
                if (DumpStart) begin
                    stateNext     = RUN;
                    dumpValidNext = 1'b1;
                    dumpIdxNext   = '0;
                    dumpDataNext  = regsNext[0];
                end
            end
            RUN: begin
                if (DumpValid && DumpReady) begin
                    if (DumpIdx == ADDR_W'(NREGS - 1)) begin
                        stateNext     = DONE;
                        dumpValidNext = 1'b0;
                        dumpDoneNext  = 1'b1;
                    end else begin
                        dumpIdxNext  = idxInc;
                        dumpDataNext = rdInc;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Dump state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Register array, scoreboard and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            OutA      <= '0;
            OutB      <= '0;
            BusyA     <= 1'b0;
            BusyB     <= 1'b0;
            DumpValid <= 1'b0;
            DumpIdx   <= '0;
            DumpData  <= '0;
            DumpDone  <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wrHit[i]) begin
                    regs[i] <= InData;
                end
            end
            busy      <= busyNext;
            OutA      <= rdA;
            OutB      <= rdB;
            BusyA     <= bzA;
            BusyB     <= bzB;
            DumpValid <= dumpValidNext;
            DumpIdx   <= dumpIdxNext;
            DumpData  <= dumpDataNext;
            DumpDone  <= dumpDoneNext;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: drives a 4-entry plain instance and a 6-entry instance with
// hardwired-zero r0 from shared stimulus, checking both against an array model.
module tb_regfile_param;

    logic       clock;
    logic       reset;
    logic       we;
    logic [2:0] wrReg;
    logic [7:0] inData;
    logic [2:0] readA;
    logic [2:0] readB;
    logic       markBusy;
    logic [2:0] markReg;
    logic       dumpStart;
    logic       dumpReady;

    logic [7:0] outA0, outB0, dData0;
    logic       busyA0, busyB0, dValid0, dDone0;
    logic [1:0] dIdx0;
    logic [7:0] outAZ, outBZ, dDataZ;
    logic       busyAZ, busyBZ, dValidZ, dDoneZ;
    logic [2:0] dIdxZ;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = plain 4-entry, index 1 = 6-entry zero-reg.
    int nregs [2] = '{4, 6};
    int zr    [2] = '{0, 1};
    int mem   [2][8];
    int bsy   [2][8];
    int phase [2];
    int eOutA [2], eOutB [2], eBusyA [2], eBusyB [2];
    int eValid[2], eIdx [2], eData [2], eDone [2];

    regfile_param #(.WIDTH(8), .NREGS(4), .ZERO_REG(0)) dut0 (
        .clock(clock), .reset(reset), .WE(we), .WrReg(wrReg[1:0]), .InData(inData),
        .ReadA(readA[1:0]), .ReadB(readB[1:0]), .OutA(outA0), .OutB(outB0),
        .MarkBusy(markBusy), .MarkReg(markReg[1:0]), .BusyA(busyA0), .BusyB(busyB0),
        .DumpStart(dumpStart), .DumpReady(dumpReady), .DumpValid(dValid0),
        .DumpIdx(dIdx0), .DumpData(dData0), .DumpDone(dDone0)
    );

    regfile_param #(.WIDTH(8), .NREGS(6), .ZERO_REG(1)) dutZ (
        .clock(clock), .reset(reset), .WE(we), .WrReg(wrReg), .InData(inData),
        .ReadA(readA), .ReadB(readB), .OutA(outAZ), .OutB(outBZ),
        .MarkBusy(markBusy), .MarkReg(markReg), .BusyA(busyAZ), .BusyB(busyBZ),
        .DumpStart(dumpStart), .DumpReady(dumpReady), .DumpValid(dValidZ),
        .DumpIdx(dIdxZ), .DumpData(dDataZ), .DumpDone(dDoneZ)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int eff(input int c, input logic [2:0] x);
        return (c == 0) ? (int'(x) & 3) : int'(x);
    endfunction

    function automatic int legal(input int c, input int a);
        return (a < nregs[c] && !(zr[c] == 1 && a == 0)) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic modelStep();
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                for (int a = 0; a < 8; a++) begin
                    mem[c][a] = 0;
                    bsy[c][a] = 0;
                end
                phase[c] = 0;
                eOutA[c] = 0; eOutB[c] = 0; eBusyA[c] = 0; eBusyB[c] = 0;
                eValid[c] = 0; eIdx[c] = 0; eData[c] = 0; eDone[c] = 0;
            end else begin
                int w = eff(c, wrReg);
                int m = eff(c, markReg);
                int ra = eff(c, readA);
                int rb = eff(c, readB);
                if (we && legal(c, w) == 1) begin
                    mem[c][w] = int'(inData);
                    bsy[c][w] = 0;
                end
                if (markBusy && legal(c, m) == 1) bsy[c][m] = 1;
                eOutA[c]  = (ra < nregs[c]) ? mem[c][ra] : 0;
                eOutB[c]  = (rb < nregs[c]) ? mem[c][rb] : 0;
                eBusyA[c] = (ra < nregs[c]) ? bsy[c][ra] : 0;
                eBusyB[c] = (rb < nregs[c]) ? bsy[c][rb] : 0;
                eDone[c]  = 0;
                if (phase[c] == 0) begin
                    if (dumpStart) begin
                        phase[c] = 1; eValid[c] = 1; eIdx[c] = 0; eData[c] = mem[c][0];
                    end
                end else if (phase[c] == 1) begin
                    if (dumpReady) begin
                        if (eIdx[c] == nregs[c] - 1) begin
                            phase[c] = 2; eValid[c] = 0; eDone[c] = 1;
                        end else begin
                            eIdx[c]++;
                            eData[c] = mem[c][eIdx[c]];
                        end
                    end
                end else begin
                    phase[c] = 0;
                end
            end
        end
    endtask

    task automatic checkAll();
        chk("outA0",  32'(outA0),   32'(eOutA[0]));
        chk("outB0",  32'(outB0),   32'(eOutB[0]));
        chk("busyA0", 32'(busyA0),  32'(eBusyA[0]));
        chk("busyB0", 32'(busyB0),  32'(eBusyB[0]));
        chk("valid0", 32'(dValid0), 32'(eValid[0]));
        chk("idx0",   32'(dIdx0),   32'(eIdx[0]));
        chk("data0",  32'(dData0),  32'(eData[0]));
        chk("done0",  32'(dDone0),  32'(eDone[0]));
        chk("outAZ",  32'(outAZ),   32'(eOutA[1]));
        chk("outBZ",  32'(outBZ),   32'(eOutB[1]));
        chk("busyAZ", 32'(busyAZ),  32'(eBusyA[1]));
        chk("busyBZ", 32'(busyBZ),  32'(eBusyB[1]));
        chk("validZ", 32'(dValidZ), 32'(eValid[1]));
        chk("idxZ",   32'(dIdxZ),   32'(eIdx[1]));
        chk("dataZ",  32'(dDataZ),  32'(eData[1]));
        chk("doneZ",  32'(dDoneZ),  32'(eDone[1]));
    endtask

    task automatic cyc();
        @(posedge clock);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic quiet();
        we = 1'b0; markBusy = 1'b0; dumpStart = 1'b0; reset = 1'b0;
    endtask

    int xfers;
    int dones;
    int expBeat [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

    initial begin
        reset = 1'b1; we = 1'b0; wrReg = '0; inData = '0; readA = '0; readB = '0;
        markBusy = 1'b0; markReg = '0; dumpStart = 1'b0; dumpReady = 1'b1;
        cyc();
        cyc();
        chk("rst_outA", 32'(outA0), 32'h0);
        chk("rst_valid", 32'(dValid0), 32'h0);
        reset = 1'b0;

        // Write-first bypass and unwritten register.
        we = 1'b1; wrReg = 3'd2; inData = 8'h5A; readA = 3'd2; readB = 3'd3;
        cyc();
        chk("bypassA", 32'(outA0), 32'h5A);
        chk("untouchedB", 32'(outB0), 32'h00);

        // Hardwired zero register.
        we = 1'b1; wrReg = 3'd0; inData = 8'hFF; readA = 3'd0; readB = 3'd0;
        markBusy = 1'b1; markReg = 3'd0;
        cyc();
        chk("zeroA", 32'(outAZ), 32'h0);
        chk("zeroB", 32'(outBZ), 32'h0);
        chk("zeroBusy", 32'(busyAZ), 32'h0);
        quiet();
        cyc();
        chk("zeroBusyHeld", 32'(busyAZ), 32'h0);

        // Scoreboard: mark, clear by write, simultaneous mark+write.
        markBusy = 1'b1; markReg = 3'd1; readA = 3'd1;
        cyc();
        markBusy = 1'b0;
        cyc();
        chk("busyMarked", 32'(busyA0), 32'h1);
        we = 1'b1; wrReg = 3'd1; inData = 8'h11;
        cyc();
        chk("busyCleared", 32'(busyA0), 32'h0);
        markBusy = 1'b1; markReg = 3'd1;
        cyc();
        chk("markWins", 32'(busyA0), 32'h1);
        quiet();

        // Full-rate dump.
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; wrReg = 3'(i); inData = 8'(expBeat[i]);
            cyc();
        end
        quiet();
        dumpReady = 1'b1; dumpStart = 1'b1;
        cyc();
        dumpStart = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            chk("beatIdx", 32'(dIdx0), 32'(k));
            chk("beatData", 32'(dData0), 32'(expBeat[k]));
            chk("beatValid", 32'(dValid0), 32'h1);
        end
        cyc();
        chk("doneHigh", 32'(dDone0), 32'h1);
        chk("doneValidLow", 32'(dValid0), 32'h0);
        cyc();
        chk("doneOnce", 32'(dDone0), 32'h0);
        for (int i = 0; i < 4; i++) cyc();

        // Stalled dump with write to held index and an ignored restart.
        xfers = 0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            quiet();
            dumpStart = (i == 0 || i == 7);
            dumpReady = (i % 3 == 0);
            if (!dumpReady && phase[0] == 1 && i % 3 == 1) begin
                we = 1'b1; wrReg = 3'(eIdx[0]); inData = 8'h99;
            end
            if (dValid0 && dumpReady) xfers++;
            cyc();
            if (dDone0) dones++;
        end
        chk("stallXfers", 32'(xfers), 32'd4);
        chk("stallDones", 32'(dones), 32'd1);
        quiet();
        dumpReady = 1'b1;
        for (int i = 0; i < 3; i++) cyc();

        // Reset in the middle of a dump.
        dumpStart = 1'b1;
        cyc();
        dumpStart = 1'b0;
        cyc();
        cyc();
        reset = 1'b1; we = 1'b1; wrReg = 3'd3; inData = 8'h77;
        cyc();
        chk("midRstValid", 32'(dValid0), 32'h0);
        chk("midRstDone", 32'(dDone0), 32'h0);
        chk("midRstData", 32'(dData0), 32'h0);
        quiet();
        cyc();
        chk("postRstDone", 32'(dDone0), 32'h0);
        for (int a = 0; a < 8; a++) begin
            readA = 3'(a); readB = 3'(7 - a);
            cyc();
            chk("postRstRead", 32'(outA0), 32'h0);
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            we        = 1'($urandom_range(0, 1));
            wrReg     = 3'($urandom_range(0, 7));
            inData    = 8'($urandom_range(0, 255));
            readA     = 3'($urandom_range(0, 7));
            readB     = 3'($urandom_range(0, 7));
            markBusy  = ($urandom_range(0, 3) == 0);
            markReg   = 3'($urandom_range(0, 7));
            dumpStart = ($urandom_range(0, 9) == 0);
            dumpReady = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 2-entry, 8-bit register file used by the datapath.
- Generalised in width and depth; adds synchronous reset and registered read ports with write-first bypass.
- Adds an optional hardwired-zero register 0, a per-register busy scoreboard for the control unit's load-use interlock, and a valid/ready debug dump sequencer that streams every register out to the test harness.

Parameters:
- WIDTH, 8, data width of each register.
- NREGS, 4, number of registers (2..256).
- ADDR_W, max(1, clog2(NREGS)), address width (derived; not overridden).
- ZERO_REG, 0: if 1, register 0 always reads 0 and writes to it are discarded.

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- WE  in  1  write enable
- WrReg  in  ADDR_W  write address
- InData  in  WIDTH  write data
- ReadA  in  ADDR_W  read address, port A
- ReadB  in  ADDR_W  read address, port B
- OutA  out  WIDTH  registered read data, port A
- OutB  out  WIDTH  registered read data, port B
- MarkBusy  in  1  set the busy bit of MarkReg
- MarkReg  in  ADDR_W  register to mark busy
- BusyA  out  1  registered busy bit for ReadA
- BusyB  out  1  registered busy bit for ReadB
- DumpStart  in  1  begin a dump of all registers
- DumpReady  in  1  consumer ready
- DumpValid  out  1  DumpIdx/DumpData valid
- DumpIdx  out  ADDR_W  index being dumped
- DumpData  out  WIDTH  register value being dumped
- DumpDone  out  1  one-cycle pulse after the last transfer

Behaviour:
- Reset (reset=1 at a rising edge) clears all of the following; reset overrides every other input that cycle:
  - all registers to 0
  - OutA, OutB, BusyA, BusyB to 0
  - all busy bits to 0
  - DumpValid, DumpIdx, DumpData, DumpDone to 0
  - FSM to IDLE
- Write:
  - At the edge, if WE=1 and WrReg<NREGS, reg[WrReg] takes InData.
  - Discarded if WrReg>=NREGS, or if ZERO_REG=1 and WrReg=0.
- Read: one-cycle latency.
  - OutA after edge k equals the value of reg[ReadA] including any write performed at edge k (write-first bypass). OutB likewise.
  - Out-of-range address reads 0.
  - With ZERO_REG=1, address 0 reads 0.
  - ReadA=ReadB is legal.
- Scoreboard:
  - MarkBusy sets busy[MarkReg].
  - An accepted write clears busy[WrReg].
  - Same register marked and written at the same edge: the bit ends set (mark wins).
  - Out-of-range MarkReg is ignored.
  - ZERO_REG=1 with MarkReg=0 is ignored; busy[0] stays 0.
  - BusyA/BusyB after edge k reflect the post-edge busy bits of ReadA/ReadB (bypass applies). Out-of-range address reads 0.
- Dump FSM, states IDLE, RUN, DONE:
  - IDLE: DumpStart=1 -> RUN. Set DumpIdx=0, capture DumpData=reg[0] (post-write value of that edge), DumpValid=1. DumpStart in RUN/DONE is ignored.
  - RUN, transfer (DumpValid & DumpReady at an edge):
    - If DumpIdx<NREGS-1: increment DumpIdx, capture the new register into DumpData, keep DumpValid=1.
    - If DumpIdx=NREGS-1: DumpValid->0, go to DONE, DumpDone->1.
  - RUN, DumpReady=0: DumpIdx/DumpData are held stable. A later write to the held register does not alter DumpData.
  - DONE: DumpDone is high for exactly one cycle, then IDLE.
  - The dump never blocks normal reads or writes.
  - Reset mid-dump: immediate return to IDLE, with no DumpDone pulse.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then with NREGS=4, WIDTH=8: write 0x5A to r2, ReadA=2 at the same edge -> OutA=0x5A one cycle later (bypass); ReadB=3 -> OutB=0x00.
- ZERO_REG=1: write 0xFF to r0, read r0 on both ports -> OutA=OutB=0x00; busy[0] stays 0 after MarkBusy with MarkReg=0.
- MarkBusy r1, then ReadA=1 -> BusyA=1. Write 0x11 to r1 -> BusyA=0 next cycle. Mark and write r1 at the same edge -> BusyA=1.
- Load r0..r3 with 0x10,0x21,0x32,0x43, pulse DumpStart with DumpReady=1 -> four consecutive beats of idx/data (0,0x10)…(3,0x43), then DumpDone high for 1 cycle, then IDLE.
- Dump with DumpReady toggling 1,0,0,1… and a write of 0x99 to the held index during the stall -> held DumpData unchanged; exactly NREGS transfers; DumpStart asserted mid-dump is ignored.
- Assert reset during beat 2 of a dump and after writes -> next cycle all outputs 0, DumpValid=0, no DumpDone, all registers read 0.
